// File: rtl/router_ingress_if.sv
// Source-side and FIFO-side signals of the router ingress controller.
// Latency: n/a (signal bundle only).
// Backpressure: busy from the controller stalls the source; fifo_full stalls the controller.
interface router_ingress_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  pkt_valid;
   logic [DATA_WIDTH-1:0] data_in;
   logic [2:0]            fifo_full;
   logic [2:0]            fifo_empty;
   logic                  busy;
   logic [DATA_WIDTH-1:0] dout;
   logic [2:0]            write_enb;
   logic                  lfd_state;
   logic                  err;
   logic                  parity_done;

   // Source and FIFO side: drives packet bytes and FIFO status, observes the controller.
   modport master (
      output pkt_valid, data_in, fifo_full, fifo_empty,
      input  busy, dout, write_enb, lfd_state, err, parity_done
   );

   // Controller side.
   modport slave (
      input  pkt_valid, data_in, fifo_full, fifo_empty,
      output busy, dout, write_enb, lfd_state, err, parity_done
   );
endinterface

// File: rtl/router_ingress_ctrl.sv
// Router ingress: decodes destination, registers bytes onto the shared FIFO bus, checks parity.
// Latency: header reaches the FIFO 2 cycles after acceptance (LOAD_FIRST, then first LOAD_DATA write).
// Backpressure: busy holds the source while waiting for an empty FIFO, on full, and during parity wrap-up.
module router_ingress_ctrl #(
   parameter int         DATA_WIDTH   = 8,
   parameter logic [1:0] INVALID_ADDR = 2'd3
) (
   input logic              clk,
   input logic              rst,
   router_ingress_if.slave  bus
);

   typedef enum logic [2:0] {
      DECODE,
      DROP,
      WAIT_EMPTY,
      LOAD_FIRST,
      LOAD_DATA,
      LOAD_PARITY,
      CHECK_PARITY
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic [1:0]            addr;
   logic [DATA_WIDTH-1:0] dout_q;
   logic [DATA_WIDTH-1:0] parity;
   logic [DATA_WIDTH-1:0] rx_parity;
   logic                  err_q;

   logic [1:0]            hdr_addr;
   logic                  sel_full;
   logic                  sel_empty;
   logic [2:0]            addr_onehot;

   logic                  busy_c;
   logic [2:0]            write_enb_c;
   logic                  lfd_c;
   logic                  parity_done_c;
   logic                  ld_hdr;
   logic                  ld_byte;
   logic                  ld_par;
   logic                  chk;

   // Destination bits of the byte on the bus (only meaningful when it is a header).
   assign hdr_addr    = bus.data_in[1:0];
   // Only the latched destination's flags matter; other FIFOs are ignored.
   assign sel_full    = bus.fifo_full[addr];
   assign sel_empty   = bus.fifo_empty[addr];
   assign addr_onehot = 3'b001 << addr;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= DECODE;
      else     state <= state_nxt;
   end

   // Next state, handshake outputs and datapath load strobes.
   always_comb begin
      state_nxt     = state;
      busy_c        = 1'b0;
      write_enb_c   = 3'b000;
      lfd_c         = 1'b0;
      parity_done_c = 1'b0;
      ld_hdr        = 1'b0;
      ld_byte       = 1'b0;
      ld_par        = 1'b0;
      chk           = 1'b0;
      unique case (state)
         DECODE: begin
            if (bus.pkt_valid) begin
               if (hdr_addr == INVALID_ADDR) begin
                  state_nxt = DROP;
               end else begin
                  ld_hdr    = 1'b1;
                  // addr is not latched yet, so look at the header's own destination.
                  state_nxt = bus.fifo_empty[hdr_addr] ? LOAD_FIRST : WAIT_EMPTY;
               end
            end
         end
         DROP: begin
            // Swallow bytes until the parity byte (pkt_valid low) has gone by.
            if (!bus.pkt_valid) state_nxt = DECODE;
         end
         WAIT_EMPTY: begin
            busy_c = 1'b1;
            if (sel_empty) state_nxt = LOAD_FIRST;
         end
         LOAD_FIRST: begin
            busy_c    = 1'b1;
            lfd_c     = 1'b1;
            state_nxt = LOAD_DATA;
         end
         LOAD_DATA: begin
            busy_c = sel_full;
            if (!sel_full) begin
               write_enb_c = addr_onehot;
               if (bus.pkt_valid) begin
                  ld_byte = 1'b1;
               end else begin
                  ld_par    = 1'b1;
                  state_nxt = LOAD_PARITY;
               end
            end
         end
         LOAD_PARITY: begin
            busy_c = 1'b1;
            if (!sel_full) begin
               write_enb_c = addr_onehot;
               state_nxt   = CHECK_PARITY;
            end
         end
         CHECK_PARITY: begin
            busy_c        = 1'b1;
            parity_done_c = 1'b1;
            chk           = 1'b1;
            state_nxt     = DECODE;
         end
         default: begin
            state_nxt = DECODE;
         end
      endcase
   end

   // Datapath: output byte register, running parity, received parity and error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr      <= 2'd0;
         dout_q    <= '0;
         parity    <= '0;
         rx_parity <= '0;
         err_q     <= 1'b0;
      end else begin
         if (ld_hdr) begin
            addr   <= hdr_addr;
            dout_q <= bus.data_in;
            parity <= bus.data_in;
         end
         if (ld_byte) begin
            dout_q <= bus.data_in;
            parity <= parity ^ bus.data_in;
         end
         if (ld_par) begin
            dout_q    <= bus.data_in;
            rx_parity <= bus.data_in;
         end
         // err persists until the next packet's check or reset.
         if (chk) err_q <= (parity != rx_parity);
      end
   end

   assign bus.busy        = busy_c;
   assign bus.dout        = dout_q;
   assign bus.write_enb   = write_enb_c;
   assign bus.lfd_state   = lfd_c;
   assign bus.err         = err_q;
   assign bus.parity_done = parity_done_c;

endmodule
